// File: rtl/dmem_if.sv
// Data-memory request/response bundle between the core (master) and the memory responder (slave).
interface dmem_if #(
   parameter int WIDTH = 32,
   parameter int DADDR = 10
);
   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [2:0]       req_funct3;
   logic [DADDR-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;
   logic             resp_valid;
   logic             resp_ready;
   logic [WIDTH-1:0] resp_rdata;
   logic             resp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder with RV32I byte/half/word sizing and alignment checks.
// Define DMEM_INIT_CLEAR_EN to zero the whole RAM, one word per cycle, after every reset.
module dmem_responder #(
   parameter int WIDTH   = 32,
   parameter int DADDR   = 10,
   parameter int LATENCY = 1
) (
   input  logic  clk,
   input  logic  reset,
   dmem_if.slave bus
);
   localparam int WORDS = 2 ** (DADDR - 2);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
`ifdef DMEM_INIT_CLEAR_EN
   localparam logic [1:0] CLEAR     = 2'd3;
   localparam logic [1:0] RST_STATE = CLEAR;
`else
   localparam logic [1:0] RST_STATE = IDLE;
`endif

   function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] lane);
      case (f3)
         3'b000:  access_err = 1'b0;
         3'b001:  access_err = lane[0];
         3'b010:  access_err = |lane;
         3'b100:  access_err = we;
         3'b101:  access_err = we | lane[0];
         default: access_err = 1'b1;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [1:0] lane,
                                                 input logic [WIDTH-1:0] w);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[8*lane +: 8];
      h = lane[1] ? w[31:16] : w[15:0];
      // funct3[2] selects zero extension (LBU/LHU)
      case (f3[1:0])
         2'b00:   load_ext = {{24{b[7] & ~f3[2]}}, b};
         2'b01:   load_ext = {{16{h[15] & ~f3[2]}}, h};
         default: load_ext = w;
      endcase
   endfunction

   function automatic logic [WIDTH-1:0] store_word(input logic [2:0] f3, input logic [WIDTH-1:0] wd);
      case (f3[1:0])
         2'b00:   store_word = {4{wd[7:0]}};
         2'b01:   store_word = {2{wd[15:0]}};
         default: store_word = wd;
      endcase
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lane);
      case (f3[1:0])
         2'b00:   store_be = 4'b0001 << lane;
         2'b01:   store_be = lane[1] ? 4'b1100 : 4'b0011;
         default: store_be = 4'b1111;
      endcase
   endfunction

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             err_q, err_d;
   logic [WIDTH-1:0] mem_q [WORDS];
`ifdef DMEM_INIT_CLEAR_EN
   logic [DADDR-3:0] clr_idx_q, clr_idx_d;
`endif

   logic             mem_we;
   logic [DADDR-3:0] mem_widx;
   logic [WIDTH-1:0] mem_wword;
   logic [3:0]       mem_be;
   logic [DADDR-3:0] req_widx;
   logic [1:0]       req_lane;
   logic [WIDTH-1:0] req_rword;
   logic             req_err;

   always_comb begin
      req_lane  = bus.req_addr[1:0];
      req_widx  = bus.req_addr[DADDR-1:2];
      req_rword = mem_q[req_widx];
      req_err   = access_err(bus.req_we, bus.req_funct3, req_lane);
      state_d   = state_q;
      cnt_d     = cnt_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      mem_we    = 1'b0;
      mem_widx  = req_widx;
      mem_wword = store_word(bus.req_funct3, bus.req_wdata);
      mem_be    = store_be(bus.req_funct3, req_lane);
`ifdef DMEM_INIT_CLEAR_EN
      clr_idx_d = clr_idx_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               err_d   = req_err;
               rdata_d = (bus.req_we || req_err) ? '0 : load_ext(bus.req_funct3, req_lane, req_rword);
               mem_we  = bus.req_we && !req_err;
               cnt_d   = CNT_LOAD;
               state_d = (LATENCY == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q <= CNT_W'(1)) state_d = RESP;
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_d = IDLE;
               rdata_d = '0;
               err_d   = 1'b0;
            end
         end
`ifdef DMEM_INIT_CLEAR_EN
         CLEAR: begin
            mem_we    = 1'b1;
            mem_widx  = clr_idx_q;
            mem_wword = '0;
            mem_be    = 4'b1111;
            clr_idx_d = clr_idx_q + 1'b1;
            if (&clr_idx_q) state_d = IDLE;
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
`ifdef DMEM_INIT_CLEAR_EN
         clr_idx_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
`ifdef DMEM_INIT_CLEAR_EN
         clr_idx_q <= clr_idx_d;
`endif
      end
   end

   // RAM is never reset; a request seen during reset must not write
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem_q[mem_widx][8*b +: 8] <= mem_wword[8*b +: 8];
         end
      end
   end

   assign bus.req_ready  = (state_q == IDLE);
   assign bus.resp_valid = (state_q == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;
endmodule
